// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus an MMIO page
// holding LEDs, a cycle counter, a compare timer and a drained output FIFO.
module dmem_mmio #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led,
    output logic             timer_irq,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    localparam logic [29:0] W_LED   = 30'h1FC0;
    localparam logic [29:0] W_CYCLE = 30'h1FC1;
    localparam logic [29:0] W_TCMP  = 30'h1FC2;
    localparam logic [29:0] W_TSTAT = 30'h1FC3;
    localparam logic [29:0] W_FIFO  = 30'h1FC4;
    localparam logic [29:0] W_FSTAT = 30'h1FC5;

    logic [31:0]      r_ram  [RAM_WORDS];
    logic [31:0]      r_fifo [FIFO_DEPTH];
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_cycle;
    logic [31:0]      r_tcmp;
    logic             r_flag;
    logic             r_ovf;
    logic [FW-1:0]    r_wp;
    logic [FW-1:0]    r_rp;
    logic [FW:0]      r_count;

    logic [29:0] w_word;
    logic        w_ram_hit;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_push_ok;
    logic        w_ovf_set;
    logic        w_hit;
    logic [31:0] w_fstat;

    assign w_word    = addr[31:2];
    assign w_ram_hit = (addr[31:AW+2] == '0);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (FW+1)'(FIFO_DEPTH));
    assign w_pop     = !w_empty && out_ready;
    assign w_push    = we && (w_word == W_FIFO);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_hit     = (r_cycle == r_tcmp) && (r_tcmp != '0);
    assign w_fstat   = {16'h0, 8'(r_count), 5'h0, r_ovf, w_full, w_empty};

    always_comb begin
        rdata = '0;
        if (w_ram_hit) begin
            rdata = r_ram[addr[AW+1:2]];
        end else begin
            unique case (1'b1)
                w_word == W_LED:   rdata = 32'(r_led);
                w_word == W_CYCLE: rdata = r_cycle;
                w_word == W_TCMP:  rdata = r_tcmp;
                w_word == W_TSTAT: rdata = {31'h0, r_flag};
                w_word == W_FSTAT: rdata = w_fstat;
                default:           rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led   <= '0;
            r_cycle <= '0;
            r_tcmp  <= '0;
            r_flag  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (we && w_word == W_LED)  r_led  <= wdata[LED_W-1:0];
            if (we && w_word == W_TCMP) r_tcmp <= wdata;
            if (w_hit)
                r_flag <= 1'b1;
            else if (we && w_word == W_TSTAT && wdata[0])
                r_flag <= 1'b0;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (we && w_word == W_FSTAT && wdata[2])
                r_ovf <= 1'b0;
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop)     r_rp <= r_rp + 1'b1;
            if (w_push_ok && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage arrays carry no reset; contents are meaningful only once written
    always_ff @(posedge clk) begin
        if (!rst && we && w_ram_hit) r_ram[addr[AW+1:2]] <= wdata;
        if (!rst && w_push_ok)       r_fifo[r_wp] <= wdata;
    end

    assign led       = r_led;
    assign timer_irq = r_flag;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 32'h0 : r_fifo[r_rp];

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory subsystem directly downstream of the single-cycle CPU's data port.
- Consumes the CPU's address (ALU result), store data and MemWrite. Returns read data in the same cycle.
- Decodes the address into a word RAM plus a small MMIO page: LED register, free-running cycle counter, compare timer with IRQ flag, and an output FIFO drained by an external valid/ready consumer.

Parameters:
- RAM_WORDS, 256, number of 32-bit RAM words; power of 2, ≤1024.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.
- LED_W, 16, width of LED register/output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  byte address from CPU ALU output.
- wdata  in  32  store data from CPU register file.
- we  in  1  CPU memory write strobe.
- rdata  out  32  read data to CPU; combinational.
- led  out  LED_W  LED register contents.
- timer_irq  out  1  timer flag level.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid=1.

Behaviour:
- Addressing: word-addressed. addr[1:0] is ignored; no byte/half accesses.
- RAM occupies 0x0000_0000 up to (RAM_WORDS*4−1), indexed by addr[log2(RAM_WORDS)+1:2].
- MMIO register map:
  - 0x0000_7F00 LED, RW. Holds LED_W bits; reads are zero-extended.
  - 0x0000_7F04 CYCLE, RO. Writes are ignored.
  - 0x0000_7F08 TCMP, RW, 32 bits.
  - 0x0000_7F0C TSTAT, RW1C. bit0 = timer flag.
  - 0x0000_7F10 FIFO_DATA, WO. A write pushes; reads return 0.
  - 0x0000_7F14 FSTAT. bit0 empty, bit1 full, bit2 overflow (RW1C), bits[15:8] count. All other bits read 0.
- Unmapped addresses: reads return 0; writes have no effect.
- Reads: purely combinational from addr, with no read side effects (the CPU has no read strobe). RAM uses an asynchronous read.
- Writes: commit at the rising edge where we=1. A read of the same address in the same cycle returns the old value.
- Reset (rst=1 at an edge):
  - Cleared: LED, CYCLE, TCMP, timer flag, FIFO pointers/count, overflow.
  - Outputs after reset: led=0, timer_irq=0, out_valid=0, out_data=0.
  - RAM contents are not reset and are undefined until written.
  - Reset overrides any simultaneous write or pop.
- CYCLE: increments by 1 every non-reset cycle. Wraps 0xFFFF_FFFF→0.
- Timer flag:
  - Set at the edge where CYCLE==TCMP and TCMP≠0.
  - Cleared by writing 1 to TSTAT bit0.
  - Set and clear in the same cycle: set wins.
  - timer_irq = flag (registered).
- FIFO:
  - Push = we & addr==FIFO_DATA; pushes wdata.
  - Pop = out_valid & out_ready.
  - out_data = head entry when non-empty, 0 when empty.
  - out_valid = (count≠0).
  - No bypass: a push into an empty FIFO makes out_valid=1 on the following cycle.
- FIFO boundary cases:
  - Push while full and no pop: data dropped, overflow bit set, count unchanged.
  - Push and pop in the same cycle while full: both happen, count stays FIFO_DEPTH, no overflow.
  - Push and pop in the same cycle otherwise: both happen, count unchanged.
  - Pop is only possible when non-empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow and write-1-clear in the same cycle: set wins.

Test Plan:
- Reset, then write RAM[0x10]=0xDEADBEEF and RAM[0x3FC]=0x12345678 -> reads return the same values. addr 0x13 aliases 0x10. Read of 0x0000_0400 -> 0.
- Write LED=0xFFFF_ABCD -> led=0xABCD next cycle; LED reads 0x0000_ABCD. Write to CYCLE -> CYCLE value is unaffected and keeps counting.
- After reset, CYCLE reads N at cycle N. Set TCMP=20 -> timer_irq rises after the edge at which CYCLE=20. Write TSTAT=1 -> irq clears. Clear issued on the same edge as a match -> flag stays 1.
- Hold out_ready=0 and push 1,2,3,4,5 -> FSTAT full=1, count=4, overflow=1. Raise out_ready -> out_data sequence is 1,2,3,4, then out_valid=0 and empty=1.
- FIFO full; push 9 with out_ready=1 in the same cycle -> count stays 4, no overflow, and 9 emerges last.
- Assert rst mid-drain with the FIFO holding 3 entries and TCMP set -> the next cycle shows out_valid=0, count=0, led=0, timer_irq=0, CYCLE=0.
